// File: rtl/ddr_read_control.sv
// ddr_read_control: fetches one image row per request from DDR through a
// request/ack arbiter port and writes the returned beats into a ping-pong
// load RAM. Frame parameters are captured on the frame-sync rising edge.
module ddr_read_control #(
    parameter int DW     = 128,
    parameter int RAM_AW = 8
) (
    input  logic              i_sclk,
    input  logic              i_rst_n,
    input  logic              i_soft_rst,
    input  logic [3:0]        i_sub_space_num,
    input  logic [11:0]       i_read_numb,
    input  logic [10:0]       i_row_total,
    input  logic [1:0]        i_wr_frame_numb,
    input  logic [15:0]       i_ddr_vpi_prio_ini,
    input  logic              i_syn_v,
    input  logic              i_ddr_req,
    output logic [RAM_AW-1:0] o_load_ram_addr,
    output logic              o_load_ram_wr,
    output logic              o_load_ram_bank,
    output logic [DW-1:0]     o_load_ram_data,
    output logic              o_ddr_vpi_req,
    input  logic              i_ddr_vpi_ack,
    output logic [26:0]       o_ddr_vpi_start_addr,
    output logic [11:0]       o_ddr_vpi_data_length,
    output logic [15:0]       o_ddr_vpi_priority,
    input  logic              i_ddr_vpi_rdata_vld,
    input  logic [DW-1:0]     i_ddr_vpi_rdata,
    input  logic              i_ddr_vpi_end,
    output logic [1:0]        o_rd_frame_numb,
    output logic              o_row_done,
    output logic              o_ddr_req_lose
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RECV     = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              rst;
    logic [2:0]        vs_sync;
    logic [2:0]        req_sync;
    logic              pos_vs;
    logic              pos_req;
    logic [3:0]        sub_space;
    logic [1:0]        rd_frame;
    logic [10:0]       row_total;
    logic [15:0]       prio_ts;
    logic [11:0]       len;
    logic [11:0]       read_len;
    logic              pending;
    logic [10:0]       row_cnt;
    logic              row_ok;
    logic [RAM_AW:0]   wcnt;
    logic              beat_ok;
    logic              burst_end;

    assign rst       = ~i_rst_n | i_soft_rst;
    assign pos_vs    = vs_sync[1] & ~vs_sync[2];
    assign pos_req   = req_sync[1] & ~req_sync[2];
    assign read_len  = ((i_read_numb == 12'd0) || (i_read_numb > 12'd256)) ? 12'd256 : i_read_numb;
    assign row_ok    = row_cnt < row_total;
    assign beat_ok   = 32'(wcnt) < 32'(len);
    assign burst_end = (state == RECV) && i_ddr_vpi_end;

    assign o_ddr_vpi_data_length = len;
    assign o_rd_frame_numb       = rd_frame;

    // Three-flop synchronisers for the asynchronous frame-sync and request levels
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            vs_sync  <= 3'd0;
            req_sync <= 3'd0;
        end else begin
            vs_sync  <= {vs_sync[1:0], i_syn_v};
            req_sync <= {req_sync[1:0], i_ddr_req};
        end
    end

    // Capture the per-frame configuration on each frame-sync edge
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            sub_space <= 4'd0;
            rd_frame  <= 2'd0;
            row_total <= 11'd0;
            prio_ts   <= 16'hFFFF;
            len       <= 12'd256;
        end else if (pos_vs) begin
            sub_space <= i_sub_space_num;
            rd_frame  <= i_wr_frame_numb;
            row_total <= i_row_total;
            prio_ts   <= i_ddr_vpi_prio_ini;
            len       <= read_len;
        end
    end

    // Pending-request flag and lost-request pulse; a new request beats a same-cycle ack
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            pending        <= 1'b0;
            o_ddr_req_lose <= 1'b0;
        end else begin
            o_ddr_req_lose <= pending & pos_req & row_ok & ~i_ddr_vpi_ack;
            if (pos_req && row_ok) begin
                pending <= 1'b1;
            end else if (i_ddr_vpi_ack) begin
                pending <= 1'b0;
            end
        end
    end

    // State register with the registered arbiter request and aging priority
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            state              <= IDLE;
            o_ddr_vpi_req      <= 1'b0;
            o_ddr_vpi_priority <= 16'hFFFF;
        end else begin
            state         <= next_state;
            o_ddr_vpi_req <= (next_state == WAIT_ACK);
            if (state == WAIT_ACK) begin
                o_ddr_vpi_priority <= (o_ddr_vpi_priority == 16'd0) ? 16'd0 : o_ddr_vpi_priority - 16'd1;
            end else begin
                o_ddr_vpi_priority <= prio_ts;
            end
        end
    end

    // Next-state logic: request, wait for grant, receive until burst end
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:     next_state = pending ? WAIT_ACK : IDLE;
            WAIT_ACK: next_state = i_ddr_vpi_ack ? RECV : WAIT_ACK;
            RECV: begin
                if (i_ddr_vpi_end) begin
                    next_state = pending ? WAIT_ACK : IDLE;
                end else begin
                    next_state = RECV;
                end
            end
            default:  next_state = IDLE;
        endcase
    end

    // DDR start address for the current row, refreshed every cycle
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            o_ddr_vpi_start_addr <= 27'd0;
        end else begin
            o_ddr_vpi_start_addr <= {sub_space, rd_frame, row_cnt, 10'd0};
        end
    end

    // Load-RAM write port; beats past the row length are discarded
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            wcnt            <= '0;
            o_load_ram_wr   <= 1'b0;
            o_load_ram_addr <= '0;
            o_load_ram_data <= '0;
        end else begin
            o_load_ram_wr   <= (state == RECV) && i_ddr_vpi_rdata_vld && beat_ok;
            o_load_ram_addr <= wcnt[RAM_AW-1:0];
            o_load_ram_data <= i_ddr_vpi_rdata;
            if (state != RECV) begin
                wcnt <= '0;
            end else if (i_ddr_vpi_rdata_vld && beat_ok) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    // Row bookkeeping: advance row and swap bank per burst, restart on frame sync
    always_ff @(posedge i_sclk) begin
        if (rst) begin
            row_cnt         <= 11'd0;
            o_load_ram_bank <= 1'b0;
            o_row_done      <= 1'b0;
        end else begin
            o_row_done <= burst_end;
            if (pos_vs) begin
                row_cnt         <= 11'd0;
                o_load_ram_bank <= 1'b0;
            end else if (burst_end) begin
                row_cnt         <= row_cnt + 11'd1;
                o_load_ram_bank <= ~o_load_ram_bank;
            end
        end
    end

endmodule
